mips_pipeline_stage_reg: RTL and testbench
==========================================

// Module: mips_pipeline_stage_reg
// PURPOSE
//   Generic, parametrised inter-stage pipeline register for the MIPS pipeline
//   (IfId/IdEx/ExMem/MemWb). Carries a packed stage bundle of WIDTH bits.
//   Uses a valid/ready handshake with flush (bubble insertion) and a
//   saturating stall-cycle counter. Replaces the per-stage hand-written
//   registers, which are driven from the combinational stage "generate" blocks.
// PARAMETERS
//   WIDTH        32     width of packed stage bundle (inData/outData)
//   RESET_VALUE  0      WIDTH-bit bubble value loaded on reset and flush
//   CNT_W        16     width of stallCount
// PORTS
//   clock       input   1        rising-edge clock
//   reset       input   1        synchronous, active-low reset
//   inValid     input   1        upstream bundle valid
//   inReady     output  1        stage can accept inData this cycle
//   inData      input   WIDTH    upstream packed bundle
//   outValid    output  1        outData holds a live bundle
//   outReady    input   1        downstream consumes outData this cycle
//   outData     output  WIDTH    registered bundle
//   flush       input   1        kill stage contents (branch/exception)
//   stallCount  output  CNT_W    cycles with outValid && !outReady
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low. When reset is 0 at a
//     clock edge: outValid=0, outData=RESET_VALUE, stallCount=0, skid cleared.
//   - Transfer in: inValid && inReady at an edge. Transfer out: outValid &&
//     outReady at an edge.
//   - Latency: 1 cycle. A bundle accepted at edge N is on outData after edge N.
//   - Base mode (no skid): inReady = !outValid || outReady (combinational).
//     At an edge with inReady: outValid<=inValid. If inValid: outData<=inData.
//     Otherwise outData holds its value.
//   - Stall: outValid && !outReady. outData and outValid hold and inReady=0.
//     Data is never dropped or duplicated.
//   - Flush, sampled at an edge, has priority over all transfers:
//     outValid<=0 and outData<=RESET_VALUE. Any same-cycle input is consumed
//     and discarded.
//     inReady is forced to 1 while flush=1, so upstream never deadlocks.
//   - Flush with reset: reset wins. Flush while stalled clears the stall.
//   - stallCount increments at each edge where outValid && !outReady and
//     flush=0. It saturates at 2^CNT_W-1 with no wrap. It is cleared only by
//     reset.
//   - Every output is a function of registered state, except base-mode
//     inReady.
// CONFIGURATION
//   MIPS_PIPELINE_STAGE_SKID_EN defined: two-entry skid buffer (main plus
//   skid register).
//     - inReady = !skidValid is a register, so there is no combinational
//       ready path.
//     - Accept while stalled (main full, !outReady) captures into skid.
//     - At an edge with transfer out and skidValid: main<=skid and skid
//       clears. An inData accepted that same edge goes to skid.
//     - Ordering is strictly FIFO. Flush clears both entries. Throughput is
//       still 1 per cycle.
//   Not defined: no skid register; inReady is combinational as in base mode.
// TESTING
//   1. Hold reset=0 for 2 edges -> outValid=0, outData=RESET_VALUE,
//      stallCount=0, inReady=1.
//   2. Stream 0x11,0x22,0x33 with outReady=1 -> same values on outData 1
//      cycle later, no gaps; stallCount stays 0.
//   3. Send 0xAA, hold outReady=0 for 3 cycles -> outData stays 0xAA;
//      stallCount=3; 0xBB in skid (SKID_EN) or held upstream (no SKID_EN).
//      Release -> 0xAA then 0xBB.
//   4. Assert flush with outValid=1 and inValid=1 (0xCC) -> next cycle
//      outValid=0, outData=RESET_VALUE; 0xCC never appears.
//   5. CNT_W=2, stall 6 cycles -> stallCount reads 1,2,3,3,3,3.
//   6. Drive reset=0 mid-stall with skid full -> after edge all state clears;
//      outputs as in test 1.

Source files
------------

// File: rtl/mips_pipeline_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush bubbles and a saturating stall counter.
// Define MIPS_PIPELINE_STAGE_SKID_EN to add a skid entry and make inReady a pure register output.
module mips_pipeline_stage_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    input  logic             flush,
    output logic [CNT_W-1:0] stallCount
);

    typedef enum logic [1:0] {
        SRC_HOLD   = 2'd0,
        SRC_IN     = 2'd1,
        SRC_SKID   = 2'd2,
        SRC_BUBBLE = 2'd3
    } main_src_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             main_valid_reg;
    logic             main_valid_next;
    logic [WIDTH-1:0] main_data_reg;
    logic [WIDTH-1:0] main_data_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;
    logic [WIDTH-1:0] skid_data;
    logic             in_ready;
    logic             stalled;
    main_src_t        main_src;

    assign stalled = main_valid_reg && !outReady;

    // A flush cycle is not counted as a stall: the stalled bundle is being killed.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stalled && !flush && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

`ifdef MIPS_PIPELINE_STAGE_SKID_EN
    logic             skid_valid_reg;
    logic             skid_valid_next;
    logic [WIDTH-1:0] skid_data_reg;
    logic [WIDTH-1:0] skid_data_next;
    logic             ready_reg;
    logic             in_fire;
    logic             main_free;
    logic             load_skid;

    assign in_ready  = ready_reg;
    assign in_fire   = inValid && ready_reg;
    assign main_free = !main_valid_reg || outReady;
    assign skid_data = skid_data_reg;

    always_comb begin
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        main_src        = SRC_HOLD;
        load_skid       = 1'b0;
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
            main_src        = SRC_BUBBLE;
        end else if (main_free) begin
            if (skid_valid_reg) begin
                // Older skid entry moves forward first to keep FIFO order.
                main_valid_next = 1'b1;
                main_src        = SRC_SKID;
                skid_valid_next = in_fire;
                load_skid       = in_fire;
            end else begin
                main_valid_next = in_fire;
                if (in_fire) begin
                    main_src = SRC_IN;
                end
            end
        end else if (in_fire) begin
            skid_valid_next = 1'b1;
            load_skid       = 1'b1;
        end
    end

    always_comb begin
        skid_data_next = skid_data_reg;
        if (flush) begin
            skid_data_next = RESET_VALUE;
        end else if (load_skid) begin
            skid_data_next = inData;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= RESET_VALUE;
            ready_reg      <= 1'b1;
        end else begin
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            ready_reg      <= !skid_valid_next;
        end
    end
`else
    // Flush forces ready so an upstream stage can always drain into the bubble.
    assign in_ready  = flush || !main_valid_reg || outReady;
    assign skid_data = RESET_VALUE;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_src        = SRC_HOLD;
        if (flush) begin
            main_valid_next = 1'b0;
            main_src        = SRC_BUBBLE;
        end else if (!main_valid_reg || outReady) begin
            main_valid_next = inValid;
            if (inValid) begin
                main_src = SRC_IN;
            end
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_main_mux
            always_comb begin
                case (main_src)
                    SRC_IN:     main_data_next[gi] = inData[gi];
                    SRC_SKID:   main_data_next[gi] = skid_data[gi];
                    SRC_BUBBLE: main_data_next[gi] = RESET_VALUE[gi];
                    default:    main_data_next[gi] = main_data_reg[gi];
                endcase
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= RESET_VALUE;
            stall_cnt_reg  <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            stall_cnt_reg  <= stall_cnt_next;
        end
    end

    assign inReady    = in_ready;
    assign outValid   = main_valid_reg;
    assign outData    = main_data_reg;
    assign stallCount = stall_cnt_reg;

endmodule

// File: tb/tb_mips_pipeline_stage_reg.sv
// Bench for mips_pipeline_stage_reg: fixed vector table, corner sequences and random traffic
// checked against a queue-based model of the stage contents.
module tb_mips_pipeline_stage_reg;

    localparam logic [31:0] RV = 32'h0000_BEEF;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic [31:0] inData;
    logic        outReady;
    logic        flush;
    logic        inReady;
    logic        outValid;
    logic [31:0] outData;
    logic [15:0] stallCount;
    logic        in2_ready;
    logic        out2_valid;
    logic [31:0] out2_data;
    logic [1:0]  cnt2;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mq[$];
    logic [31:0] m_last;
    int          m_cnt;
    int          m_cnt2;

    always #5 clock = ~clock;

    mips_pipeline_stage_reg #(.WIDTH(32), .RESET_VALUE(RV), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
        .inData(inData), .outValid(outValid), .outReady(outReady),
        .outData(outData), .flush(flush), .stallCount(stallCount)
    );

    mips_pipeline_stage_reg #(.WIDTH(32), .RESET_VALUE(RV), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(in2_ready),
        .inData(inData), .outValid(out2_valid), .outReady(outReady),
        .outData(out2_data), .flush(flush), .stallCount(cnt2)
    );

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        e_rdy;
        logic        e_v;
        logic [31:0] e_d;
        logic [15:0] e_c;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic logic model_ready();
`ifdef MIPS_PIPELINE_STAGE_SKID_EN
        return mq.size() < 2;
`else
        return flush || (mq.size() == 0) || outReady;
`endif
    endfunction

    task automatic model_edge();
        logic rdy;
        rdy = model_ready();
        if (!reset) begin
            mq.delete();
            m_cnt  = 0;
            m_cnt2 = 0;
            m_last = RV;
        end else if (flush) begin
            mq.delete();
            m_last = RV;
        end else begin
            if (mq.size() > 0 && !outReady) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (mq.size() > 0 && outReady) begin
                $display("xfer out %h", mq[0]);
                void'(mq.pop_front());
            end
            if (inValid && rdy) mq.push_back(inData);
            if (mq.size() > 0) m_last = mq[0];
        end
    endtask

    task automatic model_checks();
        chk("inReady", {31'd0, inReady}, {31'd0, model_ready()});
        chk("outValid", {31'd0, outValid}, {31'd0, mq.size() > 0});
        chk("outData", outData, m_last);
        chk("stallCount", {16'd0, stallCount}, m_cnt);
        chk("w2_inReady", {31'd0, in2_ready}, {31'd0, model_ready()});
        chk("w2_outValid", {31'd0, out2_valid}, {31'd0, mq.size() > 0});
        chk("w2_outData", out2_data, m_last);
        chk("w2_stallCount", {30'd0, cnt2}, m_cnt2);
    endtask

    task automatic drive(input logic rs, input logic iv, input logic [31:0] d,
                         input logic ordy, input logic fl);
        reset    = rs;
        inValid  = iv;
        inData   = d;
        outReady = ordy;
        flush    = fl;
    endtask

    task automatic cycle(input logic rs, input logic iv, input logic [31:0] d,
                         input logic ordy, input logic fl, input bit do_chk);
        drive(rs, iv, d, ordy, fl);
        @(negedge clock);
        if (do_chk) model_checks();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    initial begin
        vec_t tbl[12];
        int   exp5[6];

        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        mq.delete();
        m_last = RV;
        m_cnt  = 0;
        m_cnt2 = 0;
        @(posedge clock);
        #1;

        // reset held for two edges
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

`ifndef MIPS_PIPELINE_STAGE_SKID_EN
        //           iv    d             ordy  fl    rdy   v     data          cnt
        tbl[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, RV,           16'd0};
        tbl[1]  = '{1'b1, 32'h11,       1'b1, 1'b0, 1'b1, 1'b0, RV,           16'd0};
        tbl[2]  = '{1'b1, 32'h22,       1'b1, 1'b0, 1'b1, 1'b1, 32'h11,       16'd0};
        tbl[3]  = '{1'b1, 32'h33,       1'b1, 1'b0, 1'b1, 1'b1, 32'h22,       16'd0};
        tbl[4]  = '{1'b1, 32'hAA,       1'b1, 1'b0, 1'b1, 1'b1, 32'h33,       16'd0};
        tbl[5]  = '{1'b1, 32'hBB,       1'b0, 1'b0, 1'b0, 1'b1, 32'hAA,       16'd0};
        tbl[6]  = '{1'b1, 32'hBB,       1'b0, 1'b0, 1'b0, 1'b1, 32'hAA,       16'd1};
        tbl[7]  = '{1'b1, 32'hBB,       1'b0, 1'b0, 1'b0, 1'b1, 32'hAA,       16'd2};
        tbl[8]  = '{1'b1, 32'hBB,       1'b1, 1'b0, 1'b1, 1'b1, 32'hAA,       16'd3};
        tbl[9]  = '{1'b1, 32'hCC,       1'b0, 1'b1, 1'b1, 1'b1, 32'hBB,       16'd3};
        tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, RV,           16'd3};
        tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, RV,           16'd3};
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            @(negedge clock);
            $display("vec %0d iv=%b d=%h ordy=%b fl=%b -> rdy=%b v=%b d=%h cnt=%0d",
                     i, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl,
                     inReady, outValid, outData, stallCount);
            chk("tbl_inReady", {31'd0, inReady}, {31'd0, tbl[i].e_rdy});
            chk("tbl_outValid", {31'd0, outValid}, {31'd0, tbl[i].e_v});
            chk("tbl_outData", outData, tbl[i].e_d);
            chk("tbl_stallCount", {16'd0, stallCount}, {16'd0, tbl[i].e_c});
            model_checks();
            @(posedge clock);
            model_edge();
            #1;
        end
`endif

        // 2-bit counter saturation: reads 1,2,3,3,3,3
        exp5 = '{1, 2, 3, 3, 3, 3};
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
            $display("sat stall %0d cnt2=%0d cnt=%0d", k, cnt2, stallCount);
            chk("sat_cnt2", {30'd0, cnt2}, exp5[k]);
            chk("sat_cnt", {16'd0, stallCount}, k + 1);
        end

        // reset in the middle of a stall with a waiting input
        cycle(1'b1, 1'b1, 32'h66, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h77, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        $display("mid-stall reset v=%b d=%h cnt=%0d rdy=%b", outValid, outData, stallCount, inReady);
        chk("rst_outValid", {31'd0, outValid}, 32'd0);
        chk("rst_outData", outData, RV);
        chk("rst_stallCount", {16'd0, stallCount}, 32'd0);
        chk("rst_inReady", {31'd0, inReady}, 32'd1);

        for (int n = 0; n < 1500; n++) begin
            cycle(($urandom_range(63) != 0),
                  ($urandom_range(3) != 0),
                  $urandom,
                  ($urandom_range(2) != 0),
                  ($urandom_range(15) == 0),
                  1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
